// File: rtl/geom_pkg.sv
// Shared types and constants for the midpoint-to-vertex recovery block.
package geom_pkg;

  localparam int COORD_W_DEFAULT = 8;
  localparam int NUM_COORDS      = 6;
  localparam int IDX_W           = 3;

  typedef logic signed [COORD_W_DEFAULT-1:0] coord_t;
  typedef logic signed [COORD_W_DEFAULT+1:0] wide_t;

  typedef enum logic [1:0] {LOAD, COMPUTE, SEND} state_e;

  // Input frame order: midpoints D, E, F as x/y pairs.
  localparam logic [IDX_W-1:0] IDX_DX = 3'd0;
  localparam logic [IDX_W-1:0] IDX_DY = 3'd1;
  localparam logic [IDX_W-1:0] IDX_EX = 3'd2;
  localparam logic [IDX_W-1:0] IDX_EY = 3'd3;
  localparam logic [IDX_W-1:0] IDX_FX = 3'd4;
  localparam logic [IDX_W-1:0] IDX_FY = 3'd5;
  localparam logic [IDX_W-1:0] IDX_LAST = 3'(NUM_COORDS - 1);

endpackage

// File: rtl/vertex_from_midpoints.sv
// One-axis vertex recovery: p + q - r, with clamp or wrap on overflow.
module vertex_from_midpoints
  import geom_pkg::*;
#(
  parameter int W        = COORD_W_DEFAULT,
  parameter bit SATURATE = 1'b1
) (
  input  logic signed [W-1:0] p_i,
  input  logic signed [W-1:0] q_i,
  input  logic signed [W-1:0] r_i,
  output logic signed [W-1:0] res_o,
  output logic                oor_o
);

  // Two guard bits cover the worst case |p|+|q|+|r| of three W-bit values.
  localparam logic signed [W+1:0] MAXV = $signed({3'b000, {(W-1){1'b1}}});
  localparam logic signed [W+1:0] MINV = $signed({3'b111, {(W-1){1'b0}}});

  logic signed [W+1:0] p_w, q_w, r_w, sum_w;

  assign p_w   = {{2{p_i[W-1]}}, p_i};
  assign q_w   = {{2{q_i[W-1]}}, q_i};
  assign r_w   = {{2{r_i[W-1]}}, r_i};
  assign sum_w = p_w + q_w - r_w;

  // Range check, then clamp to the nearest bound or keep the low bits.
  always_comb begin
    oor_o = (sum_w > MAXV) || (sum_w < MINV);
    res_o = sum_w[W-1:0];
    if (oor_o && SATURATE) begin
      res_o = (sum_w > MAXV) ? MAXV[W-1:0] : MINV[W-1:0];
    end
  end

endmodule

// File: rtl/median_vertex_recover.sv
// Recovers triangle vertices A, B, C from side midpoints D, E, F over a
// byte stream: load six coordinates, compute one vertex per cycle, send six.
module median_vertex_recover
  import geom_pkg::*;
#(
  parameter int COORD_W  = COORD_W_DEFAULT,
  parameter bit SATURATE = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic signed [COORD_W-1:0] in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic signed [COORD_W-1:0] out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_last,
  output logic                      ovf,
  output logic                      busy
);

  state_e                    state_q;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [1:0]                vcnt_q;
  logic                      in_ready_q, out_valid_q, out_last_q, ovf_q;
  logic signed [COORD_W-1:0] out_data_q;
  logic signed [COORD_W-1:0] in_q  [NUM_COORDS];
  logic signed [COORD_W-1:0] res_q [NUM_COORDS];

  logic signed [COORD_W-1:0] px, qx, rx, py, qy, ry;
  logic signed [COORD_W-1:0] vx_d, vy_d;
  logic                      oorx, oory;
  logic [IDX_W-1:0]          ridx_x, ridx_y;
  logic                      accept, out_fire;

  assign accept   = in_valid && in_ready_q;
  assign out_fire = out_valid_q && out_ready;
  assign idx_d    = idx_q + 3'd1;
  assign ridx_x   = {vcnt_q, 1'b0};
  assign ridx_y   = {vcnt_q, 1'b1};

  // Operand routing per compute step: A = D+F-E, B = D+E-F, C = E+F-D.
  always_comb begin
    px = in_q[IDX_EX]; qx = in_q[IDX_FX]; rx = in_q[IDX_DX];
    py = in_q[IDX_EY]; qy = in_q[IDX_FY]; ry = in_q[IDX_DY];
    case (vcnt_q)
      2'd0: begin
        px = in_q[IDX_DX]; qx = in_q[IDX_FX]; rx = in_q[IDX_EX];
        py = in_q[IDX_DY]; qy = in_q[IDX_FY]; ry = in_q[IDX_EY];
      end
      2'd1: begin
        px = in_q[IDX_DX]; qx = in_q[IDX_EX]; rx = in_q[IDX_FX];
        py = in_q[IDX_DY]; qy = in_q[IDX_EY]; ry = in_q[IDX_FY];
      end
      default: ;
    endcase
  end

  vertex_from_midpoints #(.W(COORD_W), .SATURATE(SATURATE)) u_vx (
    .p_i(px), .q_i(qx), .r_i(rx), .res_o(vx_d), .oor_o(oorx)
  );

  vertex_from_midpoints #(.W(COORD_W), .SATURATE(SATURATE)) u_vy (
    .p_i(py), .q_i(qy), .r_i(ry), .res_o(vy_d), .oor_o(oory)
  );

  // Frame FSM: LOAD six bytes, COMPUTE three vertices, SEND six bytes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOAD;
      idx_q       <= '0;
      vcnt_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      ovf_q       <= 1'b0;
      for (int i = 0; i < NUM_COORDS; i++) begin
        in_q[i]  <= '0;
        res_q[i] <= '0;
      end
    end else begin
      case (state_q)
        LOAD: begin
          if (accept) begin
            in_q[idx_q] <= in_data;
            if (idx_q == '0) ovf_q <= 1'b0;
            if (idx_q == IDX_LAST) begin
              idx_q      <= '0;
              vcnt_q     <= '0;
              in_ready_q <= 1'b0;
              state_q    <= COMPUTE;
            end else begin
              idx_q <= idx_d;
            end
          end
        end
        COMPUTE: begin
          res_q[ridx_x] <= vx_d;
          res_q[ridx_y] <= vy_d;
          if (oorx || oory) ovf_q <= 1'b1;
          if (vcnt_q == 2'd2) begin
            // Ax was written two cycles ago, so it is ready to present.
            state_q     <= SEND;
            out_valid_q <= 1'b1;
            out_data_q  <= res_q[0];
            out_last_q  <= 1'b0;
          end else begin
            vcnt_q <= vcnt_q + 2'd1;
          end
        end
        SEND: begin
          if (out_fire) begin
            if (idx_q == IDX_LAST) begin
              idx_q       <= '0;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              out_data_q  <= '0;
              in_ready_q  <= 1'b1;
              state_q     <= LOAD;
            end else begin
              idx_q      <= idx_d;
              out_data_q <= res_q[idx_d];
              out_last_q <= (idx_d == IDX_LAST);
            end
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign ovf       = ovf_q;
  assign busy      = (state_q != LOAD) || (idx_q != '0);

endmodule

// File: tb/tb_median_vertex_recover.sv
// Directed bench for median_vertex_recover with a scoreboard of expected bytes.
module tb_median_vertex_recover;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic signed [7:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic signed [7:0] out_data;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic              out_last;
  logic              ovf;
  logic              busy;

  median_vertex_recover #(.COORD_W(8), .SATURATE(1'b1)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic       ovf;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;
  int last_acc_cyc = 0;
  int bp_mode = 0;
  int ph = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: A = D+F-E, B = D+E-F, C = E+F-D, clamped to [-128,127].
  task automatic push_frame(input int f[6]);
    int r[6];
    logic ov;
    exp_t e;
    r[0] = f[0] + f[4] - f[2];
    r[1] = f[1] + f[5] - f[3];
    r[2] = f[0] + f[2] - f[4];
    r[3] = f[1] + f[3] - f[5];
    r[4] = f[2] + f[4] - f[0];
    r[5] = f[3] + f[5] - f[1];
    ov = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (r[i] > 127)  begin r[i] = 127;  ov = 1'b1; end
      if (r[i] < -128) begin r[i] = -128; ov = 1'b1; end
    end
    for (int i = 0; i < 6; i++) begin
      e.data = r[i][7:0];
      e.last = (i == 5);
      e.ovf  = ov;
      q.push_back(e);
    end
  endtask

  // Present one byte (after an optional idle gap) until it is accepted.
  task automatic send_byte(input logic [7:0] b, input int gapmax, output int acc_cyc);
    logic acc;
    int n;
    in_valid = 1'b0;
    repeat ($urandom_range(0, gapmax)) begin @(posedge clk); #1; end
    in_data  = b;
    in_valid = 1'b1;
    acc = 1'b0;
    n = 0;
    acc_cyc = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      acc_cyc = cyc;
      @(posedge clk); #1;
      n++;
    end
    if (!acc) chk("in_accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input int f[6], input int gapmax, input bit chk_ovf0);
    int ac;
    push_frame(f);
    for (int i = 0; i < 6; i++) begin
      send_byte(f[i][7:0], gapmax, ac);
      if (i == 0 && chk_ovf0) chk("ovf_clear_byte0", {31'd0, ovf}, 32'd0);
      if (i == 5) last_acc_cyc = ac;
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 400) begin @(posedge clk); n++; end
    chk("drain", q.size(), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Downstream ready: always 1, or the 0,0,1 stall pattern.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (bp_mode != 0) begin
        ph = (ph + 1) % 3;
        out_ready = (ph == 2);
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  // Output monitor: scoreboard pop, hold-while-stalled, latency, no overlap.
  logic       pv = 1'b0, pstall = 1'b0, hl = 1'b0;
  logic [7:0] hd = '0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (pstall) begin
        chk("hold_valid", {31'd0, out_valid}, 32'd1);
        chk("hold_data", {24'd0, out_data}, {24'd0, hd});
        chk("hold_last", {31'd0, out_last}, {31'd0, hl});
      end
      if (out_valid && !pv) chk("latency", cyc - last_acc_cyc, 32'd4);
      if (out_valid) chk("in_ready_low_send", {31'd0, in_ready}, 32'd0);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_out", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("out_data", {24'd0, out_data}, {24'd0, e.data});
          chk("out_last", {31'd0, out_last}, {31'd0, e.last});
          chk("ovf", {31'd0, ovf}, {31'd0, e.ovf});
        end
      end
      pstall = out_valid && !out_ready;
      hd = out_data;
      hl = out_last;
      pv = out_valid;
    end else begin
      pstall = 1'b0;
      pv = 1'b0;
    end
  end

  initial begin
    int f1[6], f2[6], f3[6], fr[6];
    int ac;
    f1 = '{2, 0, 2, 3, 0, 3};
    f2 = '{-10, 5, 20, -4, 3, 7};
    f3 = '{-128, 0, 127, 0, 127, 0};

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk("rst_out_last", {31'd0, out_last}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    // Basic frames, including saturation and ovf clearing on the next frame
    send_frame(f1, 0, 1'b0);
    wait_drain();
    send_frame(f2, 0, 1'b0);
    wait_drain();
    send_frame(f3, 0, 1'b0);
    // Next frame offered immediately: its first byte is held during SEND
    send_frame(f1, 0, 1'b1);
    wait_drain();

    // Backpressure on the output
    bp_mode = 1;
    send_frame(f2, 0, 1'b0);
    wait_drain();
    bp_mode = 0;

    // Random gaps on input, back-to-back random frames
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 6; j++) fr[j] = int'($urandom_range(0, 255)) - 128;
      send_frame(fr, 3, 1'b0);
    end
    wait_drain();

    // Reset mid-frame abandons the partial input
    for (int j = 0; j < 3; j++) send_byte(f2[j][7:0], 0, ac);
    chk("busy_partial", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst2_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst2_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst2_busy", {31'd0, busy}, 32'd0);
    send_frame(f1, 0, 1'b0);
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
